move_sched: RTL
===============

Name: move_sched

Overview:
- Sequencer for the legal-move-generator datapath behind the control Avalon slave.
- On start, scans the 8 board-state rows (32-bit words, 8 x 4-bit squares) from board RAM and issues one generate request per square holding a piece of the side to move.
- Collects the destination squares streamed back and writes packed moves into the move-list RAM region.
- Reports busy, done, move count and overflow to the control register.

Parameters:
- MAX_MOVES, 100, move-list capacity (entries at move-list index 0..MAX_MOVES-1)
- ML_AW, 7, move-list index width; must satisfy 2^ML_AW >= MAX_MOVES

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  level run request from control register bit 0
- side  input  1  side to move: 0 white, 1 black; sampled on the start rising edge
- busy  output  1  run in progress
- done  output  1  run complete; held until start is low
- move_count  output  ML_AW  moves written in the current/last run
- overflow  output  1  more than MAX_MOVES moves offered
- brd_rd  output  1  board RAM read strobe
- brd_addr  output  3  board row 0..7
- brd_rdata  input  32  row data, valid 1 cycle after brd_rd; square file f occupies bits [4f+3:4f]
- gen_req  output  1  generate request
- gen_square  output  6  {row, file}
- gen_piece  output  4  piece code of the requested square
- gen_ack  input  1  1-cycle accept of gen_req
- gen_mv_valid  input  1  destination beat valid
- gen_mv_dst  input  6  destination square
- gen_sq_done  input  1  last beat for the square; may coincide with gen_mv_valid, or arrive alone when there are zero moves
- gen_mv_ready  output  1  scheduler accepts beats
- ml_we  output  1  move-list write enable
- ml_addr  output  ML_AW  write index
- ml_wdata  output  16  {gen_piece[3:0], gen_square[5:0], gen_mv_dst[5:0]}

Behaviour:
- Piece code: 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king; bit 3 = black; codes 7 and 15 are treated as empty.
- Reset values: busy=0, done=0, move_count=0, overflow=0, all strobes/req/ready=0, address/data outputs=0, FSM=IDLE.
- FSM states:
  - IDLE: a start rising edge (start=1 now, 0 the previous cycle) latches side, clears move_count and overflow, sets row=0, goes to RD_ROW, sets busy=1.
  - RD_ROW: brd_rd=1, brd_addr=row; then LATCH.
  - LATCH: register brd_rdata, file=0; then SCAN.
  - SCAN: one file per cycle. If the piece is non-empty and its bit 3 equals side, go to REQ. Otherwise advance the file. After file 7, row++ and go to RD_ROW, or go to DONE when row was 7.
  - REQ: gen_req=1 with gen_square/gen_piece held stable until gen_ack; then COLLECT.
  - COLLECT: gen_mv_ready=1. Each valid beat with move_count<MAX_MOVES gives ml_we=1, ml_addr=move_count, move_count+1 on the next edge. Beats at move_count==MAX_MOVES are dropped and set overflow. On gen_sq_done, return to SCAN at the next file, or go to RD_ROW / DONE as in SCAN.
  - DONE: busy=0, done=1; go to IDLE when start=0, which clears done.
- start=0 in any busy state aborts: FSM returns to IDLE next cycle, busy=0, done=0, move_count holds, outstanding gen_req is dropped.
- Re-arm after completion requires start low for at least 1 cycle.
- ml_we never asserts outside COLLECT.
- move_count saturates at MAX_MOVES.
- Empty-board run timing: start sampled at cycle 0, done=1 at cycle 81 (8 rows x 10 cycles, plus 1).

Optional Feature:
- MOVE_SCHED_PERF_EN defined: adds output port cycle_count[15:0].
  - Cleared on the start rising edge.
  - Increments every cycle while busy, saturating at 0xFFFF.
  - Holds its value in DONE/IDLE.
- Undefined: no port and no counter logic.

Decomposition:
- Package move_sched_pkg holds:
  - piece code constants (EMPTY..KING, BLACK_BIT=3)
  - FSM state enum
  - ml_wdata field widths
- One natural sub-module, move_sched_rowscan: registered row holder plus a file counter.
  - Outputs: match flag, current piece, row-exhausted flag for a given side.

Test Plan:
- Empty board, side=0, start rising → no gen_req; done=1 at cycle 81; move_count=0; overflow=0.
- Row 0=0x0000_0020 (white knight, square 1), side=0; stub acks in 2 cycles and returns dst 16, 18, 11 with gen_sq_done on the third beat → ml writes at indices 0/1/2 with data {2,1,16}...; move_count=3; done=1.
- Same board, side=1 → knight skipped; no gen_req; move_count=0.
- Row 7=0x0000_000A (black knight, square 56), side=1; stub gives zero moves (gen_sq_done alone) → one gen_req with gen_square=56, gen_piece=0xA; no ml_we; done=1.
- Overflow: stub returns 120 beats for one square → exactly 100 ml_we; move_count=100; overflow=1; run completes.
- Mid-run aborts:
  - Drop start during COLLECT → IDLE next cycle, busy=0, done=0; re-raise start → fresh run, move_count cleared.
  - Assert reset (0) mid-run → all outputs at reset values immediately.

Source files
------------

// File: rtl/move_sched_pkg.sv
// Shared definitions for the move_sched sequencer: piece codes, FSM states,
// and the packed move-list word layout {piece, from-square, to-square}.
package move_sched_pkg;

    // Piece kinds live in code[2:0]; code[BLACK_BIT] selects the colour.
    localparam logic [2:0] EMPTY  = 3'd0;
    localparam logic [2:0] PAWN   = 3'd1;
    localparam logic [2:0] KNIGHT = 3'd2;
    localparam logic [2:0] BISHOP = 3'd3;
    localparam logic [2:0] ROOK   = 3'd4;
    localparam logic [2:0] QUEEN  = 3'd5;
    localparam logic [2:0] KING   = 3'd6;
    localparam int BLACK_BIT = 3;

    localparam int PIECE_W = 4;
    localparam int SQ_W    = 6;
    localparam int FILES   = 8;
    localparam int ROW_W   = PIECE_W * FILES;
    localparam int ML_DW   = PIECE_W + 2 * SQ_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ROW,
        S_LATCH,
        S_SCAN,
        S_REQ,
        S_COLLECT,
        S_DONE
    } state_t;

    // Kind 7 has no piece assigned, so 7 and 15 count as empty squares.
    function automatic logic is_piece(input logic [PIECE_W-1:0] code);
        logic result;
        case (code[2:0])
            EMPTY:                                   result = 1'b0;
            PAWN, KNIGHT, BISHOP, ROOK, QUEEN, KING: result = 1'b1;
            default:                                 result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/move_sched_rowscan.sv
// Holds one board row and walks its eight squares, flagging pieces that
// belong to the side to move.
module move_sched_rowscan
    import move_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n_i,
    input  logic               load_i,
    input  logic [ROW_W-1:0]   row_data_i,
    input  logic               adv_i,
    input  logic               side_i,
    output logic [PIECE_W-1:0] piece_o,
    output logic [2:0]         file_o,
    output logic               match_o,
    output logic               last_file_o
);

    logic [ROW_W-1:0]   row_q;
    logic [2:0]         file_q;
    logic [PIECE_W-1:0] sq_piece [FILES];

    for (genvar gi = 0; gi < FILES; gi++) begin : g_sq
        assign sq_piece[gi] = row_q[PIECE_W*gi +: PIECE_W];
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            row_q  <= '0;
            file_q <= '0;
        end else if (load_i) begin
            row_q  <= row_data_i;
            file_q <= '0;
        end else if (adv_i) begin
            file_q <= file_q + 3'd1;
        end
    end

    assign piece_o     = sq_piece[file_q];
    assign file_o      = file_q;
    assign match_o     = is_piece(piece_o) && (piece_o[BLACK_BIT] == side_i);
    assign last_file_o = (file_q == 3'd7);

endmodule

// File: rtl/move_sched.sv
// Legal-move-generator sequencer: scans board rows, issues generate requests and
// packs returned destinations into the move list. MOVE_SCHED_PERF_EN adds cycle_count.
module move_sched
    import move_sched_pkg::*;
#(
    parameter int MAX_MOVES = 100,
    parameter int ML_AW     = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               side,
    output logic               busy,
    output logic               done,
    output logic [ML_AW-1:0]   move_count,
    output logic               overflow,
    output logic               brd_rd,
    output logic [2:0]         brd_addr,
    input  logic [ROW_W-1:0]   brd_rdata,
    output logic               gen_req,
    output logic [SQ_W-1:0]    gen_square,
    output logic [PIECE_W-1:0] gen_piece,
    input  logic               gen_ack,
    input  logic               gen_mv_valid,
    input  logic [SQ_W-1:0]    gen_mv_dst,
    input  logic               gen_sq_done,
    output logic               gen_mv_ready,
    output logic               ml_we,
    output logic [ML_AW-1:0]   ml_addr,
    output logic [ML_DW-1:0]   ml_wdata
`ifdef MOVE_SCHED_PERF_EN
    ,
    output logic [15:0]        cycle_count
`endif
);

    localparam logic [ML_AW-1:0] MAX_CNT = ML_AW'(MAX_MOVES);

    state_t             state_q;
    logic               start_prev_q;
    logic               side_q;
    logic [2:0]         row_q;
    logic               busy_q;
    logic               done_q;
    logic               ovf_q;
    logic [ML_AW-1:0]   cnt_q;
    logic               brd_rd_q;
    logic [2:0]         brd_addr_q;
    logic               gen_req_q;
    logic [SQ_W-1:0]    gen_square_q;
    logic [PIECE_W-1:0] gen_piece_q;
    logic               ready_q;

    logic               start_rise;
    logic               scan_load;
    logic               scan_match;
    logic               scan_last;
    logic [PIECE_W-1:0] scan_piece;
    logic [2:0]         scan_file;
    logic               leave_sq;
    logic               wr_acc;

    assign start_rise = start && !start_prev_q;
    assign scan_load  = (state_q == S_LATCH);

    // Finished with the current square: skipped in SCAN, or its beats ended.
    assign leave_sq = start && (((state_q == S_SCAN) && !scan_match) ||
                                ((state_q == S_COLLECT) && gen_sq_done));

    assign wr_acc = start && (state_q == S_COLLECT) && gen_mv_valid && (cnt_q < MAX_CNT);

    move_sched_rowscan u_rowscan (
        .clk         (clk),
        .rst_n_i     (reset),
        .load_i      (scan_load),
        .row_data_i  (brd_rdata),
        .adv_i       (leave_sq),
        .side_i      (side_q),
        .piece_o     (scan_piece),
        .file_o      (scan_file),
        .match_o     (scan_match),
        .last_file_o (scan_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            side_q       <= 1'b0;
            row_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            cnt_q        <= '0;
            brd_rd_q     <= 1'b0;
            brd_addr_q   <= '0;
            gen_req_q    <= 1'b0;
            gen_square_q <= '0;
            gen_piece_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            start_prev_q <= start;
            brd_rd_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_rise) begin
                        side_q     <= side;
                        cnt_q      <= '0;
                        ovf_q      <= 1'b0;
                        row_q      <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        brd_rd_q   <= 1'b1;
                        brd_addr_q <= '0;
                        state_q    <= S_RD_ROW;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    if (!start) begin
                        // Abort: drop any handshake in flight but keep the count.
                        busy_q    <= 1'b0;
                        done_q    <= 1'b0;
                        gen_req_q <= 1'b0;
                        ready_q   <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        case (state_q)
                            S_RD_ROW: state_q <= S_LATCH;
                            S_LATCH:  state_q <= S_SCAN;
                            S_SCAN: begin
                                if (scan_match) begin
                                    gen_req_q    <= 1'b1;
                                    gen_square_q <= {row_q, scan_file};
                                    gen_piece_q  <= scan_piece;
                                    state_q      <= S_REQ;
                                end
                            end
                            S_REQ: begin
                                if (gen_ack) begin
                                    gen_req_q <= 1'b0;
                                    ready_q   <= 1'b1;
                                    state_q   <= S_COLLECT;
                                end
                            end
                            S_COLLECT: begin
                                if (wr_acc) begin
                                    cnt_q <= cnt_q + 1'b1;
                                end else if (gen_mv_valid) begin
                                    ovf_q <= 1'b1;
                                end
                                if (gen_sq_done) begin
                                    ready_q <= 1'b0;
                                    state_q <= S_SCAN;
                                end
                            end
                            default: state_q <= S_IDLE;
                        endcase

                        if (leave_sq && scan_last) begin
                            if (row_q == 3'd7) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                row_q      <= row_q + 3'd1;
                                brd_rd_q   <= 1'b1;
                                brd_addr_q <= row_q + 3'd1;
                                state_q    <= S_RD_ROW;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign move_count   = cnt_q;
    assign overflow     = ovf_q;
    assign brd_rd       = brd_rd_q;
    assign brd_addr     = brd_addr_q;
    assign gen_req      = gen_req_q;
    assign gen_square   = gen_square_q;
    assign gen_piece    = gen_piece_q;
    assign gen_mv_ready = ready_q;
    assign ml_we        = wr_acc;
    assign ml_addr      = cnt_q;
    assign ml_wdata     = wr_acc ? {gen_piece_q, gen_square_q, gen_mv_dst} : '0;

`ifdef MOVE_SCHED_PERF_EN
    logic [15:0] cyc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
        end else if ((state_q == S_IDLE) && start_rise) begin
            cyc_q <= '0;
        end else if (busy_q && (cyc_q != 16'hFFFF)) begin
            cyc_q <= cyc_q + 16'd1;
        end
    end

    assign cycle_count = cyc_q;
`endif

endmodule
